// File: rtl/spi_wishbone_master.sv
// SPI-slave (mode 0) to Wishbone-classic master bridge: one 8-bit read or write per frame.
// SPI pins are oversampled in the clk domain; SCK never clocks a flop.
module spi_wishbone_master #(
    parameter int SYNC_STAGES = 2,
    parameter int WB_TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sck,
    input  logic       spi_csn,
    input  logic       spi_sdi,
    output logic       spi_sdo,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [6:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i
);

    typedef enum logic [2:0] {IDLE, CMD, WB_READ, DATA, WB_WRITE, DRAIN} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(WB_TIMEOUT - 1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sr, csn_sr, sdi_sr;
    logic                   sck_d, csn_d;
    logic                   sck_s, csn_s, sdi_s;
    logic                   sck_rise, sck_fall, csn_fall;
    logic [6:0]             shreg;
    logic [7:0]             byte_in;
    logic [7:0]             tx;
    logic [3:0]             bit_cnt;
    logic                   rw;
    logic                   abort;
    logic [15:0]            wait_cnt;
    logic                   wb_done;
    logic                   rd_late;

    assign sck_s    = sck_sr[SYNC_STAGES-1];
    assign csn_s    = csn_sr[SYNC_STAGES-1];
    assign sdi_s    = sdi_sr[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign csn_fall = ~csn_s & csn_d;
    assign byte_in  = {shreg, sdi_s};
    assign wb_done  = wb_stb_o & (wb_ack_i | (wait_cnt == WAIT_LAST));
    // Read data is only usable if the master has not yet sampled the first bit of byte1.
    assign rd_late  = (bit_cnt != 4'd0) | sck_rise | ~wb_ack_i;

    // While the read is pending, drive 1s so a late byte reads back as 0xFF.
    assign spi_sdo = ~csn_s & ~abort &
                     ((state == DATA && !rw) ? tx[7] : (state == WB_READ));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sr <= '0;
            csn_sr <= '1;
            sdi_sr <= '0;
            sck_d  <= 1'b0;
            csn_d  <= 1'b1;
        end else begin
            sck_sr <= {sck_sr[SYNC_STAGES-2:0], spi_sck};
            csn_sr <= {csn_sr[SYNC_STAGES-2:0], spi_csn};
            sdi_sr <= {sdi_sr[SYNC_STAGES-2:0], spi_sdi};
            sck_d  <= sck_s;
            csn_d  <= csn_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            tx       <= '0;
            bit_cnt  <= '0;
            rw       <= 1'b0;
            abort    <= 1'b0;
            wait_cnt <= '0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (csn_fall) begin
                        state   <= CMD;
                        bit_cnt <= '0;
                        abort   <= 1'b0;
                    end
                end
                CMD: begin
                    if (csn_s) begin
                        state <= IDLE;
                    end else if (sck_rise) begin
                        shreg   <= byte_in[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            wb_adr_o <= byte_in[6:0];
                            rw       <= byte_in[7];
                            bit_cnt  <= '0;
                            if (byte_in[7]) begin
                                state <= DATA;
                            end else begin
                                state    <= WB_READ;
                                wb_cyc_o <= 1'b1;
                                wb_stb_o <= 1'b1;
                                wait_cnt <= '0;
                            end
                        end
                    end
                end
                WB_READ: begin
                    // Keep counting byte1 bits so DATA ends on the right SCK edge.
                    if (csn_s) abort <= 1'b1;
                    if (sck_rise && !csn_s && !abort && bit_cnt != 4'd8)
                        bit_cnt <= bit_cnt + 4'd1;
                    if (wb_done) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        tx       <= rd_late ? 8'hFF : wb_dat_i;
                        if (abort || csn_s)
                            state <= IDLE;
                        else if (bit_cnt == 4'd8 || (bit_cnt == 4'd7 && sck_rise))
                            state <= DRAIN;
                        else
                            state <= DATA;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (csn_s) begin
                        state <= IDLE;
                    end else begin
                        // Falls before the first byte1 sample belong to byte0.
                        if (sck_fall && bit_cnt != 4'd0)
                            tx <= {tx[6:0], 1'b0};
                        if (sck_rise) begin
                            shreg   <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (rw) begin
                                    wb_dat_o <= byte_in;
                                    wb_cyc_o <= 1'b1;
                                    wb_stb_o <= 1'b1;
                                    wb_we_o  <= 1'b1;
                                    wait_cnt <= '0;
                                    state    <= WB_WRITE;
                                end else begin
                                    state <= DRAIN;
                                end
                            end
                        end
                    end
                end
                WB_WRITE: begin
                    if (csn_s) abort <= 1'b1;
                    if (wb_done) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        state    <= (abort || csn_s) ? IDLE : DRAIN;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DRAIN: begin
                    if (csn_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_wishbone_master.sv
// Randomized frame-level bench for spi_wishbone_master with a transaction model,
// a reactive Wishbone slave and per-cycle bus invariant checks.
module tb_spi_wishbone_master;

    localparam int TMO   = 40;
    localparam int H     = 5;
    localparam int NEVER = 100000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_sck, spi_csn, spi_sdi, spi_sdo;
    logic       wb_cyc_o, wb_stb_o, wb_we_o;
    logic [6:0] wb_adr_o;
    logic [7:0] wb_dat_o, wb_dat_i;
    logic       wb_ack_i;

    typedef struct {
        logic       we;
        logic [6:0] adr;
        logic [7:0] dat;
        int         dur;
    } cyc_t;

    int   checks   = 0;
    int   failures = 0;
    cyc_t got_q[$];
    cyc_t cur;
    bit   in_cyc;
    int   n_seen;
    int   csn_hi;
    int   slv_lat;
    logic [7:0] slv_rdata;

    spi_wishbone_master #(.SYNC_STAGES(2), .WB_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave, cycle recorder and bus invariants, all sampled on the falling clk edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            wb_ack_i = 1'b0;
            wb_dat_i = 8'h00;
            n_seen   = 0;
            in_cyc   = 1'b0;
            csn_hi   = 0;
        end else begin
            chk("cyc_eq_stb", wb_cyc_o, wb_stb_o);
            if (spi_csn) csn_hi++; else csn_hi = 0;
            if (csn_hi >= 4) chk("sdo_idle", spi_sdo, 0);
            if (wb_stb_o) begin
                if (!in_cyc) begin
                    cur.we  = wb_we_o;
                    cur.adr = wb_adr_o;
                    cur.dat = wb_dat_o;
                    cur.dur = 1;
                    in_cyc  = 1'b1;
                end else begin
                    chk("adr_stable", wb_adr_o, cur.adr);
                    chk("we_stable", wb_we_o, cur.we);
                    chk("dat_stable", wb_dat_o, cur.dat);
                    cur.dur++;
                end
                n_seen++;
                wb_ack_i = (n_seen == slv_lat + 1);
                wb_dat_i = wb_ack_i ? slv_rdata : 8'($urandom);
            end else begin
                if (in_cyc) begin
                    got_q.push_back(cur);
                    in_cyc = 1'b0;
                end
                n_seen   = 0;
                wb_ack_i = ($urandom_range(7) == 0);
                wb_dat_i = 8'($urandom);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] txb, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_sdi = txb[7-i];
            wait_clk(H);
            spi_sck   = 1'b1;
            rx[7-i]   = spi_sdo;
            wait_clk(H);
            spi_sck = 1'b0;
        end
    endtask

    task automatic wait_stb_low();
        int k = 0;
        while (wb_stb_o && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("stb_release", wb_stb_o, 0);
    endtask

    // One frame: byte0, nb1 bits of byte1, extra whole bytes; model predicts the bus cycle and SDO.
    task automatic run_frame(input bit rw, input logic [6:0] adr, input logic [7:0] data,
                             input int lat, input int nb1, input int extra,
                             output logic [7:0] rx1, output int ncyc, output cyc_t c);
        logic [7:0] rx0, rxe;
        int         exp_n;
        int         exp_dur;
        got_q.delete();
        slv_lat   = lat;
        slv_rdata = data;
        spi_csn   = 1'b0;
        wait_clk(H);
        spi_bits({rw, adr}, 8, rx0);
        spi_bits(rw ? data : 8'($urandom), nb1, rx1);
        for (int e = 0; e < extra; e++) begin
            spi_bits(8'($urandom), 8, rxe);
            chk("sdo_extra", rxe, 0);
        end
        wait_clk(H);
        spi_csn = 1'b1;
        wait_clk(4);
        wait_stb_low();
        wait_clk(8);

        exp_n   = (!rw || nb1 == 8) ? 1 : 0;
        exp_dur = (lat >= NEVER) ? TMO : lat + 1;
        ncyc    = got_q.size();
        c       = '{we: 1'b0, adr: 7'h0, dat: 8'h0, dur: 0};
        chk("sdo_cmd", rx0, 0);
        chk("cycle_count", ncyc, exp_n);
        if (ncyc > 0) begin
            c = got_q.pop_front();
            chk("cyc_we", c.we, rw);
            chk("cyc_adr", c.adr, adr);
            if (rw) chk("cyc_dat", c.dat, data);
            chk("cyc_dur", c.dur, exp_dur);
        end
        if (rw)
            chk("sdo_write", rx1, 0);
        else if (nb1 == 8)
            chk("rd_byte", rx1, (lat <= 2) ? data : 8'hFF);
    endtask

    initial begin
        logic [7:0] rx;
        int         n;
        cyc_t       c;
        int         lat, nb1, extra, sel;
        bit         rw;

        rst_n   = 1'b0;
        spi_csn = 1'b1;
        spi_sck = 1'b0;
        spi_sdi = 1'b0;
        slv_lat = 0;
        slv_rdata = 8'h00;
        wait_clk(3);
        #1;
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_sdo", spi_sdo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clk(4);

        // Write 0x85,0x3C with ack two cycles after stb.
        run_frame(1'b1, 7'h05, 8'h3C, 2, 8, 0, rx, n, c);
        chk("w_lit_n", n, 1);
        chk("w_lit_adr", c.adr, 7'h05);
        chk("w_lit_dat", c.dat, 8'h3C);
        chk("w_lit_we", c.we, 1);
        chk("w_lit_cyc_after", wb_cyc_o, 0);

        // Read 0x12 returning 0xA7 with a 1-cycle ack.
        run_frame(1'b0, 7'h12, 8'hA7, 0, 8, 0, rx, n, c);
        chk("r_lit_byte", rx, 8'hA7);
        chk("r_lit_we", c.we, 0);

        // Slow read: ack arrives after byte1 has started.
        run_frame(1'b0, 7'h40, 8'h3B, 20, 8, 0, rx, n, c);
        chk("slow_lit_byte", rx, 8'hFF);
        chk("slow_lit_dur", c.dur, 21);
        run_frame(1'b0, 7'h41, 8'h66, 1, 8, 0, rx, n, c);
        chk("after_slow_byte", rx, 8'h66);

        // Write timeout with no ack at all.
        run_frame(1'b1, 7'h22, 8'hC3, NEVER, 8, 1, rx, n, c);
        chk("tmo_lit_dur", c.dur, 40);

        // Abort after 4 bits of byte1, then a normal write.
        run_frame(1'b1, 7'h21, 8'h99, 0, 4, 0, rx, n, c);
        chk("abort_lit_n", n, 0);
        run_frame(1'b1, 7'h01, 8'h55, 1, 8, 0, rx, n, c);
        chk("post_abort_adr", c.adr, 7'h01);
        chk("post_abort_dat", c.dat, 8'h55);

        for (int f = 0; f < 30; f++) begin
            rw  = 1'($urandom_range(1));
            sel = $urandom_range(5);
            lat = (sel < 3) ? $urandom_range(2) : (sel < 5) ? $urandom_range(30, 14) : NEVER;
            nb1 = ($urandom_range(7) == 0) ? $urandom_range(7, 1) : 8;
            extra = (nb1 == 8) ? $urandom_range(1) : 0;
            run_frame(rw, 7'($urandom), 8'($urandom), lat, nb1, extra, rx, n, c);
        end

        // Asynchronous reset in the middle of a write cycle.
        got_q.delete();
        slv_lat = NEVER;
        spi_csn = 1'b0;
        wait_clk(H);
        spi_bits(8'hAA, 8, rx);
        spi_bits(8'h5E, 8, rx);
        begin
            int k = 0;
            while (!wb_stb_o && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        chk("pre_rst_stb", wb_stb_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cyc", wb_cyc_o, 0);
        chk("arst_stb", wb_stb_o, 0);
        chk("arst_we", wb_we_o, 0);
        chk("arst_sdo", spi_sdo, 0);
        spi_csn = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(8);
        chk("arst_no_cycle", got_q.size(), 0);
        run_frame(1'b0, 7'h33, 8'h5A, 0, 8, 0, rx, n, c);
        chk("post_rst_byte", rx, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
